// File: rtl/tt_um_prio_event_queue.sv
// Captures each new valid winning index from the priority encoder stage and
// queues it in a 4-deep FIFO that a host drains with a pop strobe.
module tt_um_prio_event_queue (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [2:0] DEPTH = 3'd4;

   logic [7:0] code_s1, code_s2;
   logic [2:0] ctl_s1, ctl_s2;
   logic [4:0] prev;
   logic       pop_s2_d;
   logic [3:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       overflow;
   logic       pop_ack;

   logic       cur_valid;
   logic [4:0] cur;
   logic       flush;
   logic       push_req, pop_req;
   logic       full, pop_eff, push_ok, drop;

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:3]};

   // ctl bits: [0] pop strobe, [1] flush, [2] encoder enable.
   always_comb begin
      cur_valid = (code_s2[7:4] == 4'b0000) & ctl_s2[2];
      cur       = {cur_valid, code_s2[3:0]};
      flush     = ctl_s2[1];
      push_req  = cur_valid & (cur != prev);
      pop_req   = ctl_s2[0] & ~pop_s2_d;
      full      = (count == DEPTH);
      pop_eff   = pop_req & (count != 3'd0) & ~flush;
      push_ok   = push_req & (~full | pop_eff) & ~flush;
      drop      = push_req & full & ~pop_eff & ~flush;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_s1  <= 8'h00;
         code_s2  <= 8'h00;
         ctl_s1   <= 3'b000;
         ctl_s2   <= 3'b000;
         prev     <= 5'b0;
         pop_s2_d <= 1'b0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         count    <= 3'd0;
         overflow <= 1'b0;
         pop_ack  <= 1'b0;
      end else begin
         code_s1  <= ui_in;
         code_s2  <= code_s1;
         ctl_s1   <= uio_in[2:0];
         ctl_s2   <= ctl_s1;
         prev     <= cur;
         pop_s2_d <= ctl_s2[0];
         pop_ack  <= pop_eff;
         if (flush) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop_eff) rd_ptr <= rd_ptr + 2'd1;
            if (push_ok && !pop_eff)      count <= count + 3'd1;
            else if (pop_eff && !push_ok) count <= count - 3'd1;
            if (drop) overflow <= 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; count gates every read, so stale
   // contents are never visible and the array can map to plain flops/RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= code_s2[3:0];
   end

   always_comb begin
      uo_out[3:0] = (count != 3'd0) ? mem[rd_ptr] : 4'h0;
      uo_out[4]   = (count != 3'd0);
      uo_out[5]   = full;
      uo_out[6]   = overflow;
      uo_out[7]   = pop_ack;
      uio_out     = {1'b0, count, 4'b0000};
      uio_oe      = 8'b0111_0000;
   end

endmodule

// File: tb/tb_tt_um_prio_event_queue.sv
// Randomized and directed bench for tt_um_prio_event_queue against a
// queue-based reference model of the event FIFO.
module tb_tt_um_prio_event_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in, uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   tt_um_prio_event_queue dut (
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe),
      .ena    (ena),
      .clk    (clk),
      .rst_n  (rst_n)
   );

   always #5 clk = ~clk;

   // Reference model: inputs reach the logic two edges after being sampled.
   logic [7:0] d1_code, d2_code;
   logic [2:0] d1_ctl, d2_ctl;
   logic [3:0] q[$];
   logic [4:0] m_prev;
   logic       m_pop_d, m_ovf, m_ack;

   task automatic model_clear();
      d1_code = 0; d2_code = 0; d1_ctl = 0; d2_ctl = 0;
      q.delete(); m_prev = 0; m_pop_d = 0; m_ovf = 0; m_ack = 0;
   endtask

   task automatic model_step();
      bit         valid, push, pop, pe;
      logic [4:0] c;
      logic [3:0] junk;
      valid = (d2_code[7:4] == 4'h0) && d2_ctl[2];
      c     = valid ? {1'b1, d2_code[3:0]} : 5'd0;
      push  = valid && (c != m_prev);
      pop   = d2_ctl[0] && !m_pop_d;
      if (d2_ctl[1]) begin
         q.delete();
         m_ovf = 0;
         m_ack = 0;
      end else begin
         pe = pop && (q.size() > 0);
         if (pe) junk = q.pop_front();
         if (push) begin
            if (q.size() < 4) q.push_back(d2_code[3:0]);
            else m_ovf = 1;
         end
         m_ack = pe;
      end
      m_prev  = c;
      m_pop_d = d2_ctl[0];
      d2_code = d1_code; d2_ctl = d1_ctl;
      d1_code = ui_in;   d1_ctl = uio_in[2:0];
   endtask

   always @(posedge clk) if (rst_n) model_step();

   function automatic logic [7:0] exp_uo();
      logic [3:0] head;
      head = (q.size() != 0) ? q[0] : 4'h0;
      return {m_ack, m_ovf, q.size() == 4, q.size() != 0, head};
   endfunction

   function automatic logic [7:0] exp_uio();
      logic [2:0] cnt;
      cnt = 3'(q.size());
      return {1'b0, cnt, 4'h0};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive inputs at a falling edge, let one rising edge pass, compare.
   task automatic step(input logic [7:0] ui, input logic pop, input logic flush, input logic en);
      logic [4:0] junk_bits;
      junk_bits = 5'($urandom());
      ui_in  = ui;
      uio_in = {junk_bits, en, flush, pop};
      ena    = 1'($urandom());
      @(negedge clk);
      check("uo_out", uo_out, exp_uo());
      check("uio_out", uio_out, exp_uio());
   endtask

   task automatic hold(input logic [7:0] ui, input int n);
      for (int i = 0; i < n; i++) step(ui, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_flush();
      for (int i = 0; i < 3; i++) step(8'hF0, 1'b0, 1'b1, 1'b1);
      hold(8'hF0, 3);
   endtask

   task automatic do_pop(input logic [7:0] ui);
      step(ui, 1'b1, 1'b0, 1'b1);
      step(ui, 1'b1, 1'b0, 1'b1);
      step(ui, 1'b0, 1'b0, 1'b1);
      step(ui, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      ui_in  = 8'($urandom());
      uio_in = 8'($urandom());
      ena    = 1'($urandom());
      model_clear();
      #1;
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'h70);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] fill_codes [5] = '{8'h03, 8'h07, 8'h0C, 8'h0E, 8'h01};
   logic [7:0] pop_heads  [4] = '{8'h57, 8'h5C, 8'h5E, 8'h40};

   initial begin
      rst_n = 1'b0; ui_in = 0; uio_in = 0; ena = 0;
      model_clear();
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
      check("idle_uo", uo_out, 8'h00);

      // Single capture, then no re-push while held.
      hold(8'h0A, 3);
      check("capture_uo", uo_out, 8'h1A);
      check("capture_cnt", uio_out, 8'h10);
      hold(8'h0A, 10);
      check("held_cnt", uio_out, 8'h10);

      // Fill past full, then drain.
      do_flush();
      check("flush_uo", uo_out, 8'h00);
      foreach (fill_codes[i]) hold(fill_codes[i], 4);
      check("full_uo", uo_out, 8'h73);
      check("full_cnt", uio_out, 8'h40);
      foreach (pop_heads[i]) begin
         do_pop(8'h01);
         check("drain_uo", uo_out, pop_heads[i]);
      end

      // Simultaneous push and pop while full.
      do_flush();
      for (int i = 0; i < 4; i++) hold(fill_codes[i], 4);
      check("refill_uo", uo_out, 8'h33);
      do_pop(8'h05);
      check("pushpop_cnt", uio_out, 8'h40);
      for (int i = 0; i < 3; i++) do_pop(8'h05);
      check("pushpop_last", uo_out, 8'h15);

      // Re-trigger after an invalid code; disabled encoder queues nothing.
      do_flush();
      hold(8'h02, 3); hold(8'hF0, 3); hold(8'h02, 3);
      check("retrig_uo", uo_out, 8'h12);
      check("retrig_cnt", uio_out, 8'h20);
      for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
      check("en0_cnt", uio_out, 8'h20);

      // Flush with overflow set, then pop on empty.
      foreach (fill_codes[i]) hold(fill_codes[i], 3);
      do_flush();
      check("flush_ovf", uo_out, 8'h00);
      do_pop(8'hF0);
      check("pop_empty", uo_out, 8'h00);

      // Randomized traffic with one mid-run reset.
      for (int k = 0; k < 400; k++) begin
         logic [7:0] code;
         logic       pop, fl, en;
         int         n;
         if (k == 200) do_reset();
         code = 8'($urandom());
         if ($urandom_range(9) < 7) code[7:4] = 4'h0;
         pop = ($urandom_range(2) == 0);
         fl  = ($urandom_range(24) == 0);
         en  = ($urandom_range(7) != 0);
         n   = $urandom_range(4, 1);
         for (int j = 0; j < n; j++) step(code, pop, fl, en);
      end
      check("end_oe", uio_oe, 8'h70);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
